// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer and status logic for a dual-clock FIFO: Gray read pointer,
// RAM read address, and registered empty / almost_empty / level / underflow flags.
module fifo_rptr_empty #(
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_err
);

    localparam int              PW     = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          rinc;

    always_comb begin
        rinc       = rd_en & ~empty;
        rbin_next  = rbin + PW'(rinc);
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        // Each binary bit is the XOR of all Gray bits at or above it.
        wbin       = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
        level_next = wbin - rbin_next;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin         <= '0;
            rptr         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            rd_err       <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rptr         <= rgray_next;
            empty        <= (rgray_next == rq2_wptr);
            almost_empty <= (level_next <= THRESH);
            rd_level     <= level_next;
            rd_err       <= rd_en & empty;
        end
    end

    // Address is the low bits of the binary pointer; the MSB only tracks lap parity.
    assign rd_addr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty: table-driven drain/underflow vectors,
// plus lap-wrap, simultaneous read/write and full pointer wrap sequences.
module tb_fifo_rptr_empty;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_en;
    logic [4:0] rq2_wptr;
    logic [3:0] rd_addr;
    logic [4:0] rptr;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic       rd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rd_en;
        logic [4:0] wptr;
        logic [4:0] rptr;
        logic [3:0] addr;
        logic       empty;
        logic       aempty;
        logic [4:0] level;
        logic       err;
    } vec_t;

    vec_t  vecs[8];
    vec_t  exp_q[$];
    string phase;

    fifo_rptr_empty #(.ADDR_WIDTH(4), .AEMPTY_THRESH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_en        (rd_en),
        .rq2_wptr     (rq2_wptr),
        .rd_addr      (rd_addr),
        .rptr         (rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h, expected %0h", phase, name, act, exp);
        end
    endtask

    task automatic compare(input vec_t e);
        check("rptr",         32'(rptr),         32'(e.rptr));
        check("rd_addr",      32'(rd_addr),      32'(e.addr));
        check("empty",        32'(empty),        32'(e.empty));
        check("almost_empty", 32'(almost_empty), 32'(e.aempty));
        check("rd_level",     32'(rd_level),     32'(e.level));
        check("rd_err",       32'(rd_err),       32'(e.err));
    endtask

    // Drive at the falling edge, let the rising edge act, sample at the next falling edge.
    task automatic step(input vec_t v);
        rd_en    = v.rd_en;
        rq2_wptr = v.wptr;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            compare(exp_q.pop_front());
        end
    endtask

    task automatic reset_now();
        vec_t r;
        rq2_wptr = 5'b00000;
        rd_en    = 1'b0;
        rst_n    = 1'b0;
        #1;
        r = '{1'b0, 5'b00000, 5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0};
        compare(r);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t v;

        // rd_en, wptr, exp rptr, exp addr, exp empty, exp aempty, exp level, exp err
        vecs[0] = '{1'b0, 5'b00111, 5'b00000, 4'd0, 1'b0, 1'b0, 5'd5, 1'b0};
        vecs[1] = '{1'b1, 5'b00111, 5'b00001, 4'd1, 1'b0, 1'b0, 5'd4, 1'b0};
        vecs[2] = '{1'b1, 5'b00111, 5'b00011, 4'd2, 1'b0, 1'b0, 5'd3, 1'b0};
        vecs[3] = '{1'b1, 5'b00111, 5'b00010, 4'd3, 1'b0, 1'b1, 5'd2, 1'b0};
        vecs[4] = '{1'b1, 5'b00111, 5'b00110, 4'd4, 1'b0, 1'b1, 5'd1, 1'b0};
        vecs[5] = '{1'b1, 5'b00111, 5'b00111, 4'd5, 1'b1, 1'b1, 5'd0, 1'b0};
        vecs[6] = '{1'b1, 5'b00111, 5'b00111, 4'd5, 1'b1, 1'b1, 5'd0, 1'b1};
        vecs[7] = '{1'b0, 5'b00111, 5'b00111, 4'd5, 1'b1, 1'b1, 5'd0, 1'b0};

        rst_n    = 1'b1;
        rd_en    = 1'b0;
        rq2_wptr = '0;
        @(negedge clk);
        phase = "reset_initial";
        reset_now();

        phase = "drain";
        for (int i = 0; i < 8; i++) begin
            step(vecs[i]);
        end

        // Asynchronous reset in the middle of a cycle, with a non-zero read pointer.
        phase = "reset_midrun";
        #2;
        reset_now();

        phase = "lap_wrap";
        v = '{1'b0, 5'b11000, 5'b00000, 4'd0, 1'b0, 1'b0, 5'd16, 1'b0};
        step(v);
        for (int k = 1; k <= 16; k++) begin
            logic [4:0] kb;
            kb = 5'(k);
            v.rd_en  = 1'b1;
            v.wptr   = 5'b11000;
            v.rptr   = gray(kb);
            v.addr   = kb[3:0];
            v.level  = 5'd16 - kb;
            v.empty  = (k == 16);
            v.aempty = (16 - k) <= 2;
            v.err    = 1'b0;
            step(v);
        end
        check("lap_rptr_final", 32'(rptr), 32'h18);

        phase = "simultaneous";
        v = '{1'b0, gray(5'd19), 5'b11000, 4'd0, 1'b0, 1'b0, 5'd3, 1'b0};
        step(v);
        for (int i = 1; i <= 10; i++) begin
            logic [4:0] rb;
            rb = 5'(16 + i);
            v.rd_en  = 1'b1;
            v.wptr   = gray(5'(19 + i));
            v.rptr   = gray(rb);
            v.addr   = rb[3:0];
            v.empty  = 1'b0;
            v.aempty = 1'b0;
            v.level  = 5'd3;
            v.err    = 1'b0;
            step(v);
        end

        phase = "full_wrap";
        reset_now();
        for (int n = 0; n < 32; n++) begin
            logic [4:0] nb;
            logic [4:0] nb1;
            nb  = 5'(n);
            nb1 = 5'(n + 1);
            v = '{1'b0, gray(nb1), gray(nb), nb[3:0], 1'b0, 1'b1, 5'd1, 1'b0};
            step(v);
            v = '{1'b1, gray(nb1), gray(nb1), nb1[3:0], 1'b1, 1'b1, 5'd0, 1'b0};
            step(v);
        end
        check("wrap_rptr_zero", 32'(rptr), 32'h0);
        check("wrap_addr_zero", 32'(rd_addr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rptr_empty.md
Name: fifo_rptr_empty

Overview:
- Read-domain pointer and status generator for the dual-clock asynchronous FIFO.
- Produces the Gray-coded read pointer that the r2w synchronizer carries into the write domain.
- Consumes the write pointer after it has been synchronized into the read domain.
- Generates the RAM read address plus registered empty, almost_empty, occupancy level and underflow status.

Parameters:
- ADDR_WIDTH, 4, FIFO address bits; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AEMPTY_THRESH, 2, almost_empty asserts when level <= this value.

Ports:
- clk  input  1  read-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_en  input  1  read request from the consumer.
- rq2_wptr  input  ADDR_WIDTH+1  Gray write pointer, already two-flop synchronized into clk domain.
- rd_addr  output  ADDR_WIDTH  RAM read address.
- rptr  output  ADDR_WIDTH+1  registered Gray read pointer, to the r2w synchronizer.
- empty  output  1  registered FIFO-empty flag.
- almost_empty  output  1  registered, level <= AEMPTY_THRESH.
- rd_level  output  ADDR_WIDTH+1  registered conservative occupancy, 0..2^ADDR_WIDTH.
- rd_err  output  1  one-cycle pulse on read attempt while empty.

Behaviour:
- Reset is asynchronous and active-low, effective immediately, including mid-operation.
- Reset values: internal rbin=0, rptr=0, rd_addr=0, empty=1, almost_empty=1, rd_level=0, rd_err=0.
- rinc = rd_en & ~empty.
- rbin_next = rbin + rinc, modulo 2^(ADDR_WIDTH+1).
- rgray_next = (rbin_next >> 1) ^ rbin_next.
- Every posedge: rbin <= rbin_next and rptr <= rgray_next. The rptr register feeds the synchronizer directly; no combinational path.
- rd_addr = rbin[ADDR_WIDTH-1:0], a direct register output. Data for the current read is at rd_addr. RAM read latency belongs to the memory, not this block.
- empty <= (rgray_next == rq2_wptr). empty deasserts one clk after rq2_wptr changes. empty asserts on the same edge that consumes the last entry.
- wbin = Gray-to-binary of rq2_wptr, combinational (XOR prefix from MSB).
- level_next = wbin - rbin_next, modulo 2^(ADDR_WIDTH+1).
- Each edge: rd_level <= level_next and almost_empty <= (level_next <= AEMPTY_THRESH).
- rd_level is conservative: it may under-report (write pointer lags by the synchronizer), never over-report for legal inputs.
- Illegal rq2_wptr (distance > 2^ADDR_WIDTH) is not clamped; rd_level is the modulo result.
- rd_err <= rd_en & empty. On an underflow attempt rbin, rptr and rd_addr hold.
- Wrap-around: the extra MSB distinguishes lap parity. After 2^ADDR_WIDTH reads, rd_addr returns to 0 while the rptr MSB differs. Full 2^(ADDR_WIDTH+1) wrap returns rbin to 0.
- rd_en with a simultaneous rq2_wptr advance: both take effect in the same edge computation; level is unchanged net.
- No internal state machine beyond the pointer registers; all outputs are registered.

Test Plan (ADDR_WIDTH=4, AEMPTY_THRESH=2):
1. Reset: assert rst_n=0 mid-run with rq2_wptr=0 -> immediately rptr=00000, rd_addr=0, empty=1, almost_empty=1, rd_level=0, rd_err=0.
2. Partial drain:
   - Set rq2_wptr=00111 (gray 5) -> next edge empty=0, rd_level=5, almost_empty=0.
   - Three rd_en cycles -> rptr 00001, 00011, 00010; rd_level 4, 3, 2; almost_empty=1 with level 2.
3. Drain and underflow:
   - Continue reading -> empty=1 on the edge where rptr=00111, rd_level=0.
   - Extra rd_en -> rd_err=1 for one cycle; rptr stays 00111; rd_addr stays 5.
4. Lap wrap:
   - rq2_wptr=11000 (gray 16) with rptr 0 -> rd_level=16, almost_empty=0, empty=0.
   - 16 reads -> rd_addr steps 0..15 then back to 0, rptr=11000, empty=1.
5. Simultaneous events: rd_en held high while rq2_wptr advances one Gray step per cycle, level 3 -> rd_level stays 3 and empty stays 0 throughout.
6. Full pointer wrap: cycle 32 writes and 32 reads -> rbin returns to 0, rptr=00000, empty=1, no rd_err pulses.
